// File: rtl/hdmi_packet_pkg.sv
// Purpose: packet type codes, InfoFrame index enum and index-to-type mapping shared by the data-island path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Optional feature macro: HDMI_SPD_INFOFRAME_EN adds SPD to the per-frame InfoFrame round.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;
    localparam logic [7:0] PKT_SPD          = 8'h83;

`ifdef HDMI_SPD_INFOFRAME_EN
    localparam int NUM_IF = 3;
`else
    localparam int NUM_IF = 2;
`endif

    // Index order doubles as InfoFrame priority: lowest pending index goes first.
    typedef enum logic [1:0] {
        IF_AVI   = 2'd0,
        IF_AUDIO = 2'd1,
        IF_SPD   = 2'd2
    } if_idx_e;

    function automatic logic [7:0] if_type_code(input if_idx_e idx);
        logic [7:0] code;
        case (idx)
            IF_AVI:   code = PKT_AVI;
            IF_AUDIO: code = PKT_AUDIO_IF;
            IF_SPD:   code = PKT_SPD;
            default:  code = PKT_NULL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/data_island_packet_scheduler_if.sv
// Purpose: request/grant bundle between packet generators and the data-island scheduler.
// Latency: n/a (wires only).
// Backpressure: none; the scheduler grants one source per slot via ack pulses.
// Ports: packet_enable, frame_start, acr_wrap_toggle, audio_sample_avail (requests, into scheduler);
//        packet_type, audio_sample_ack, acr_ack, infoframe_ack, acr_overrun (grants/status, out of scheduler).
interface data_island_packet_scheduler_if;
    logic       packet_enable;
    logic       frame_start;
    logic       acr_wrap_toggle;
    logic       audio_sample_avail;
    logic [7:0] packet_type;
    logic       audio_sample_ack;
    logic       acr_ack;
    logic       infoframe_ack;
    logic       acr_overrun;

    // master: the side that raises requests and consumes grants
    modport master (
        output packet_enable, frame_start, acr_wrap_toggle, audio_sample_avail,
        input  packet_type, audio_sample_ack, acr_ack, infoframe_ack, acr_overrun
    );

    // slave: the scheduler itself
    modport slave (
        input  packet_enable, frame_start, acr_wrap_toggle, audio_sample_avail,
        output packet_type, audio_sample_ack, acr_ack, infoframe_ack, acr_overrun
    );
endinterface

// File: rtl/toggle_sync_edge.sv
// Purpose: 2-flop synchroniser for a cross-domain toggle, emitting a one-cycle pulse on every change.
// Latency: pulse is high in the third clk cycle after tog_in changes (two sync flops plus edge flop).
// Backpressure: none; toggles closer than ~3 clk cycles apart can merge.
// Ports: clk, reset (sync, active-high), tog_in (async toggle), chg_pulse (one-cycle change pulse).
module toggle_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic tog_in,
    output logic chg_pulse
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;

    always_comb begin
        sync1_d = tog_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    assign chg_pulse = sync2_q ^ edge_q;
endmodule

// File: rtl/data_island_packet_scheduler.sv
// Purpose: picks ACR / audio sample / InfoFrame / null for each HDMI data-island packet slot.
// Latency: packet_type and the ack pulses are registered, valid the cycle after packet_enable.
// Backpressure: none; sources hold requests until acked, audio limited to bursts while InfoFrames wait.
// Ports: clk_pixel, reset (sync, active-high), bus (data_island_packet_scheduler_if.slave).
// Optional feature macro: HDMI_SPD_INFOFRAME_EN (adds SPD InfoFrame, 3-bit pending vector).
module data_island_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int INFOFRAME_MAX_WAIT = 4,
    parameter int AUDIO_BURST_MAX    = 3
) (
    input  logic                           clk_pixel,
    input  logic                           reset,
    data_island_packet_scheduler_if.slave  bus
);
    localparam int WW = $clog2(INFOFRAME_MAX_WAIT + 1);
    localparam int BW = $clog2(AUDIO_BURST_MAX + 1);

    logic              acr_chg;
    logic              acr_pending_q, acr_pending_d;
    logic              acr_overrun_q, acr_overrun_d;
    logic [NUM_IF-1:0] if_pending_q,  if_pending_d;
    logic [WW-1:0]     wait_count_q,  wait_count_d;
    logic [BW-1:0]     burst_count_q, burst_count_d;
    logic [7:0]        packet_type_q, packet_type_d;
    logic              audio_ack_q,   audio_ack_d;
    logic              acr_ack_q,     acr_ack_d;
    logic              if_ack_q,      if_ack_d;

    logic              any_if;
    logic [NUM_IF-1:0] sel_mask;
    logic [1:0]        sel_idx;
    logic [NUM_IF-1:0] clr_mask;
    logic              acr_clear;

    toggle_sync_edge u_acr_sync (
        .clk       (clk_pixel),
        .reset     (reset),
        .tog_in    (bus.acr_wrap_toggle),
        .chg_pulse (acr_chg)
    );

    // Lowest-index pending InfoFrame: scan downwards so the lowest set bit wins.
    always_comb begin
        sel_mask = '0;
        sel_idx  = 2'd0;
        for (int i = NUM_IF - 1; i >= 0; i--) begin
            if (if_pending_q[i]) begin
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
                sel_idx     = 2'(i);
            end
        end
    end

    assign any_if = |if_pending_q;

    always_comb begin
        packet_type_d = packet_type_q;
        audio_ack_d   = 1'b0;
        acr_ack_d     = 1'b0;
        if_ack_d      = 1'b0;
        clr_mask      = '0;
        acr_clear     = 1'b0;
        wait_count_d  = wait_count_q;
        burst_count_d = burst_count_q;

        // Decision uses registered state only, so same-cycle requests wait a slot.
        if (bus.packet_enable) begin
            if (acr_pending_q) begin
                packet_type_d = PKT_ACR;
                acr_ack_d     = 1'b1;
                acr_clear     = 1'b1;
            end else if (any_if && wait_count_q == WW'(INFOFRAME_MAX_WAIT)) begin
                packet_type_d = if_type_code(if_idx_e'(sel_idx));
                if_ack_d      = 1'b1;
                clr_mask      = sel_mask;
                wait_count_d  = '0;
                burst_count_d = '0;
            end else if (bus.audio_sample_avail &&
                         (!any_if || burst_count_q < BW'(AUDIO_BURST_MAX))) begin
                packet_type_d = PKT_AUDIO_SAMPLE;
                audio_ack_d   = 1'b1;
                if (any_if) begin
                    wait_count_d  = (wait_count_q == WW'(INFOFRAME_MAX_WAIT)) ?
                                    wait_count_q : wait_count_q + WW'(1);
                    burst_count_d = (burst_count_q == BW'(AUDIO_BURST_MAX)) ?
                                    burst_count_q : burst_count_q + BW'(1);
                end else begin
                    burst_count_d = '0;
                end
            end else if (any_if) begin
                packet_type_d = if_type_code(if_idx_e'(sel_idx));
                if_ack_d      = 1'b1;
                clr_mask      = sel_mask;
                wait_count_d  = '0;
                burst_count_d = '0;
            end else begin
                packet_type_d = PKT_NULL;
            end
        end

        // New frame re-arms every InfoFrame; still-pending bits simply stay set.
        if (bus.frame_start) begin
            wait_count_d = '0;
        end
        if_pending_d = (if_pending_q & ~clr_mask) | {NUM_IF{bus.frame_start}};

        // A fresh ACR edge beats the clear so a back-to-back request is never lost.
        acr_pending_d = acr_chg ? 1'b1 : (acr_clear ? 1'b0 : acr_pending_q);
        acr_overrun_d = acr_overrun_q | (acr_chg & acr_pending_q);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acr_pending_q <= 1'b0;
            acr_overrun_q <= 1'b0;
            if_pending_q  <= '0;
            wait_count_q  <= '0;
            burst_count_q <= '0;
            packet_type_q <= PKT_NULL;
            audio_ack_q   <= 1'b0;
            acr_ack_q     <= 1'b0;
            if_ack_q      <= 1'b0;
        end else begin
            acr_pending_q <= acr_pending_d;
            acr_overrun_q <= acr_overrun_d;
            if_pending_q  <= if_pending_d;
            wait_count_q  <= wait_count_d;
            burst_count_q <= burst_count_d;
            packet_type_q <= packet_type_d;
            audio_ack_q   <= audio_ack_d;
            acr_ack_q     <= acr_ack_d;
            if_ack_q      <= if_ack_d;
        end
    end

    assign bus.packet_type      = packet_type_q;
    assign bus.audio_sample_ack = audio_ack_q;
    assign bus.acr_ack          = acr_ack_q;
    assign bus.infoframe_ack    = if_ack_q;
    assign bus.acr_overrun      = acr_overrun_q;
endmodule

// File: doc/data_island_packet_scheduler.md
Name: data_island_packet_scheduler

Overview:
- Chooses which HDMI data-island packet fills each packet slot in the pixel clock domain.
- Candidate packets: audio clock regeneration (ACR), audio sample, per-frame InfoFrames (AVI, audio, optional SPD), and null.
- Sits between the packet generators and the packet assembler.
- Outputs a packet type code and per-source acknowledge pulses. The external header/sub mux and the audio FIFO pop are driven from these outputs.

Parameters:
- INFOFRAME_MAX_WAIT, 4: number of slots a pending InfoFrame may lose to audio samples before it outranks them.
- AUDIO_BURST_MAX, 3: maximum consecutive audio sample slots granted while an InfoFrame is pending.

Ports:
- clk_pixel  input  1  pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- packet_enable  input  1  one-cycle pulse; a new packet slot starts; the scheduler decides on this cycle.
- frame_start  input  1  one-cycle pulse at start of frame; arms the InfoFrame round.
- acr_wrap_toggle  input  1  clk_slow_wrap from the audio domain, unsynchronised.
- audio_sample_avail  input  1  audio sample FIFO holds at least one sample packet.
- packet_type  output  8  HDMI packet type for the current slot.
- audio_sample_ack  output  1  one-cycle pop pulse to the audio FIFO.
- acr_ack  output  1  one-cycle pulse; ACR packet scheduled.
- infoframe_ack  output  1  one-cycle pulse; an InfoFrame scheduled.
- acr_overrun  output  1  sticky; a new ACR request arrived while one was still pending.

Behaviour:
- Synchroniser: acr_wrap_toggle passes through a 2-flop synchroniser plus an edge-detect flop. Any change of the synchronised value sets acr_pending.
  - If acr_pending is already set at that moment, set acr_overrun. acr_overrun clears only on reset.
- frame_start sets infoframe_pending[k] for every enabled InfoFrame k and clears wait_count.
  - If bits are still pending at frame_start, they stay set; nothing is dropped.
- Decision on each packet_enable, first match wins:
  1. acr_pending → type 0x01; acr_ack; clear acr_pending.
  2. Any infoframe_pending AND wait_count == INFOFRAME_MAX_WAIT → lowest-index pending InfoFrame.
  3. audio_sample_avail AND (no InfoFrame pending OR burst_count < AUDIO_BURST_MAX) → type 0x02; audio_sample_ack.
  4. Any infoframe_pending → lowest-index pending InfoFrame.
  5. Otherwise → null, type 0x00.
- InfoFrame index and code: 0 = AVI 0x82, 1 = audio 0x84, 2 = SPD 0x83.
- When an InfoFrame is chosen: clear its pending bit, pulse infoframe_ack, reset wait_count and burst_count to 0.
- When audio is chosen while an InfoFrame is pending: increment wait_count and burst_count, each saturating at its parameter.
- When audio is chosen with no InfoFrame pending: burst_count = 0.
- Timing:
  - Acks are registered and assert the cycle after packet_enable, for exactly one cycle.
  - packet_type is registered, updates the cycle after packet_enable, and holds until the next decision.
- Simultaneous events:
  - A request arriving on the same cycle as packet_enable is not seen until the next slot.
  - frame_start coinciding with packet_enable: the decision uses the pre-frame_start state; the set takes effect after.
  - A synchronised ACR edge coinciding with the ACR clear leaves acr_pending set and sets acr_overrun.
- Reset values: packet_type = 0x00; all acks = 0; acr_overrun = 0; all pending bits = 0; counters = 0; synchroniser flops = 0.
- Reset mid-slot abandons the current decision; the output returns to null.

Optional Feature:
- Macro: HDMI_SPD_INFOFRAME_EN.
- Defined: the InfoFrame round contains AVI, audio, and SPD (3 bits).
- Undefined: the round contains AVI and audio only, type 0x83 is never emitted, and the pending vector is 2 bits wide.

Decomposition:
- Shared package hdmi_packet_pkg holds:
  - packet type localparams (NULL, ACR, AUDIO_SAMPLE, AVI, AUDIO_IF, SPD);
  - an enum for InfoFrame index;
  - the function mapping index to type code.
- Sub-module toggle_sync_edge: 2-flop synchroniser with change-pulse output. It is reused by any cross-domain toggle in the codebase.

Test Plan:
- Reset, then packet_enable every 32 cycles with no requests → packet_type 0x00 in every slot; no acks.
- Toggle acr_wrap_toggle once, then hold audio_sample_avail = 1 → next slot gives 0x01 and acr_ack, following slots give 0x02.
- frame_start with audio_sample_avail held at 1 (AUDIO_BURST_MAX = 3) → order 0x02, 0x02, 0x02, 0x82, then 0x02 ×3, 0x84, then 0x02 ×3, 0x83 (SPD macro on).
- frame_start with no audio → 0x82, 0x84, 0x83, then 0x00; exactly one infoframe_ack per InfoFrame.
- Toggle acr_wrap_toggle twice with no packet_enable in between → acr_overrun = 1 and stays set; one ACR packet emitted.
- Assert reset while acr_pending and InfoFrames are pending → after reset the next slot is 0x00 and acr_overrun = 0.
